seq_frame_tx: RTL and testbench



---
 rtl/seq_frame_pkg.sv | 21 ++
 rtl/seq_piso.sv | 28 ++
 rtl/seq_frame_tx.sv | 160 ++++++++++++++++
 tb/tb_seq_frame_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_frame_pkg.sv
// Shared types and constants for the 1010-sync serial frame transmitter.
package seq_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_DATA = 3'd2,
      ST_PAR  = 3'd3,
      ST_GAP  = 3'd4
   } state_e;

   localparam logic [3:0] SYNC_PATTERN = 4'b1010;
   localparam int         SYNC_LEN     = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register with load and shift enables.
module seq_piso #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] pdin,
   output logic         msb
);

   logic [W-1:0] sreg_q, sreg_d;

   always_comb begin
      sreg_d = sreg_q;
      if (load)       sreg_d = pdin;
      else if (shift) sreg_d = sreg_q << 1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sreg_q <= '0;
      else        sreg_q <= sreg_d;
   end

   assign msb = sreg_q[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync 1010, payload MSB-first, optional parity, gap.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx
   import seq_frame_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int GAP_BITS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
   output logic              din_ready,
   output logic              dout,
   output logic              dout_en,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(max3(DATA_W, GAP_BITS, SYNC_LEN)) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             dout_en_q, dout_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             rdy_q, rdy_d;
   logic             load, shift, msb;
   logic [1:0]       sync_idx;

`ifdef SEQ_FRAME_TX_PARITY_EN
   logic par_q, par_d;
`endif

   seq_piso #(.W(DATA_W)) u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .pdin  (din),
      .msb   (msb)
   );

   assign sync_idx = cnt_q[1:0] - 2'd1;

   // Outputs are computed for the state being entered, so they come out registered.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dout_d    = 1'b0;
      dout_en_d = 1'b0;
      done_d    = 1'b0;
      rdy_d     = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_d     = par_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (din_valid && rdy_q) begin
               state_d   = ST_SYNC;
               cnt_d     = CNT_W'(SYNC_LEN - 1);
               load      = 1'b1;
               dout_d    = SYNC_PATTERN[SYNC_LEN-1];
               dout_en_d = 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
               par_d     = ^din;
`endif
            end else begin
               rdy_d = 1'b1;
            end
         end
         ST_SYNC: begin
            dout_en_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d  = cnt_q - CNT_ONE;
               dout_d = SYNC_PATTERN[sync_idx];
            end else begin
               state_d = ST_DATA;
               cnt_d   = CNT_W'(DATA_W - 1);
               dout_d  = msb;
               shift   = 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q != '0) begin
               cnt_d     = cnt_q - CNT_ONE;
               dout_d    = msb;
               shift     = 1'b1;
               dout_en_d = 1'b1;
            end else begin
`ifdef SEQ_FRAME_TX_PARITY_EN
               state_d   = ST_PAR;
               dout_d    = par_q;
               dout_en_d = 1'b1;
`else
               state_d = ST_GAP;
               cnt_d   = CNT_W'(GAP_BITS - 1);
               done_d  = (GAP_BITS == 1);
`endif
            end
         end
`ifdef SEQ_FRAME_TX_PARITY_EN
         ST_PAR: begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(GAP_BITS - 1);
            done_d  = (GAP_BITS == 1);
         end
`endif
         ST_GAP: begin
            if (cnt_q != '0) begin
               cnt_d  = cnt_q - CNT_ONE;
               done_d = (cnt_q == CNT_ONE);
            end else begin
               state_d = ST_IDLE;
               rdy_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dout_q    <= 1'b0;
         dout_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         dout_en_q <= dout_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rdy_q     <= rdy_d;
      end
   end

`ifdef SEQ_FRAME_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end
`endif

   assign dout       = dout_q;
   assign dout_en    = dout_en_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign din_ready  = rdy_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx (DATA_W=8, GAP_BITS=2).
module tb_seq_frame_tx;

   localparam int DW  = 8;
   localparam int GAP = 2;
`ifdef SEQ_FRAME_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int F = 4 + DW + P + GAP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          din_valid = 1'b0;
   logic [DW-1:0] din = '0;
   logic          din_ready, dout, dout_en, busy, frame_done;

   int checks = 0;
   int errors = 0;

   logic cd [0:63];
   logic ce [0:63];
   logic cf [0:63];
   logic cb [0:63];
   logic cr [0:63];

   seq_frame_tx #(.DATA_W(DW), .GAP_BITS(GAP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_valid  (din_valid),
      .din        (din),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_en    (dout_en),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic exp_dout(input logic [DW-1:0] w, input int k);
      logic [3:0] sp;
      sp = 4'b1010;
      if (k < 4) return sp[3-k];
      if (k < 4 + DW) return w[DW-1-(k-4)];
      if (P == 1 && k == 4 + DW) return ^w;
      return 1'b0;
   endfunction

   task automatic send_word(input logic [DW-1:0] w, input bit hold,
                            output bit ok);
      logic rdy;
      ok = 1'b0;
      @(negedge clk);
      din = w;
      din_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         rdy = din_ready;
         @(posedge clk);
         if (rdy) ok = 1'b1;
         else @(negedge clk);
      end
      #1 din_valid = hold;
   endtask

   task automatic capture(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cd[k] = dout;
         ce[k] = dout_en;
         cf[k] = frame_done;
         cb[k] = busy;
         cr[k] = din_ready;
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({dout, dout_en, din_ready, busy, frame_done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outs got %b want 00000",
                  {dout, dout_en, din_ready, busy, frame_done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (din_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge got %b want 0", din_ready);
      end
      @(negedge clk);
      checks++;
      if (din_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_first_edge got %b want 1", din_ready);
      end
   endtask

   task automatic test_idle();
      din_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({dout, dout_en, busy, frame_done, din_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL idle_%0d got %b want 00001", i,
                     {dout, dout_en, busy, frame_done, din_ready});
         end
      end
   endtask

   task automatic test_single();
      logic [DW-1:0] w;
      bit ok;
      int pulses;
`ifdef SEQ_FRAME_TX_PARITY_EN
      w = 8'hC5;
`else
      w = 8'h3C;
`endif
      send_word(w, 1'b0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_accept got 0 want 1");
      end
      capture(F + 1);
      pulses = 0;
      for (int k = 0; k < F; k++) begin
         checks++;
         if ({cd[k], ce[k], cf[k], cb[k], cr[k]} !==
             {exp_dout(w, k), k < 4 + DW + P, k == F - 1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_k%0d got %b want %b", k,
                     {cd[k], ce[k], cf[k], cb[k], cr[k]},
                     {exp_dout(w, k), k < 4 + DW + P, k == F - 1, 1'b1, 1'b0});
         end
         if (cf[k]) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL single_pulses got %0d want 1", pulses);
      end
      checks++;
      if ({cb[F], cr[F], ce[F]} !== 3'b010) begin
         errors++;
         $display("FAIL single_end got %b want 010", {cb[F], cr[F], ce[F]});
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int rdy_cnt;
      logic [DW-1:0] w;
      send_word(8'hFF, 1'b1, ok);
      din = 8'h00;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_accept got 0 want 1");
      end
      rdy_cnt = 0;
      for (int k = 0; k < 2 * F + 1; k++) begin
         @(negedge clk);
         if (k == F + 1) din_valid = 1'b0;
         if (k < F + 1 && din_ready) rdy_cnt++;
         if (k == F) begin
            checks++;
            if ({din_ready, dout_en} !== 2'b10) begin
               errors++;
               $display("FAIL b2b_gap got %b want 10", {din_ready, dout_en});
            end
         end else begin
            w = (k < F) ? 8'hFF : 8'h00;
            checks++;
            if ({dout, frame_done} !==
                {exp_dout(w, (k < F) ? k : k - F - 1),
                 (k == F - 1) || (k == 2 * F)}) begin
               errors++;
               $display("FAIL b2b_k%0d got %b want %b", k, {dout, frame_done},
                        {exp_dout(w, (k < F) ? k : k - F - 1),
                         (k == F - 1) || (k == 2 * F)});
            end
         end
      end
      checks++;
      if (rdy_cnt != 1) begin
         errors++;
         $display("FAIL b2b_ready_cycles got %0d want 1", rdy_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      send_word(8'hA5, 1'b0, ok);
      capture(7);
      checks++;
      if ({cd[6], ce[6]} !== 2'b11) begin
         errors++;
         $display("FAIL mid_bit3 got %b want 11", {cd[6], ce[6]});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dout, dout_en, busy, frame_done} !== 4'b0) begin
         errors++;
         $display("FAIL mid_async got %b want 0000",
                  {dout, dout_en, busy, frame_done});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_done_%0d got %b want 0", i, frame_done);
         end
      end
      rst_n = 1'b1;
      send_word(8'h81, 1'b0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mid_reaccept got 0 want 1");
      end
      capture(F);
      for (int k = 0; k < F; k++) begin
         checks++;
         if ({cd[k], ce[k], cf[k]} !==
             {exp_dout(8'h81, k), k < 4 + DW + P, k == F - 1}) begin
            errors++;
            $display("FAIL mid_81_k%0d got %b want %b", k,
                     {cd[k], ce[k], cf[k]},
                     {exp_dout(8'h81, k), k < 4 + DW + P, k == F - 1});
         end
      end
   endtask

   task automatic test_detector();
      bit ok;
      logic [3:0] h;
      int hits, hit_k;
      h = 4'b0;
      for (int f = 0; f < 2; f++) begin
         send_word(8'h00, 1'b0, ok);
         capture(F + 1);
         hits = 0;
         hit_k = -1;
         for (int k = 0; k < F + 1; k++) begin
            h = {h[2:0], cd[k]};
            if (h == 4'b1010) begin
               hits++;
               hit_k = k;
            end
         end
         checks++;
         if (hits != 1 || hit_k != 3) begin
            errors++;
            $display("FAIL det_frame%0d got hits %0d at %0d want 1 at 3",
                     f, hits, hit_k);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_reset_mid();
      test_detector();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
